ofdm_rx_ctrl: RTL and testbench

Per-symbol receive sequencer for the OFDM demodulator. It waits for a captured symbol, runs the FFT core, then runs the subcarrier decoder, and hands each 96-bit payload downstream over a valid/ready register. It also owns the single FFT-result BSRAM port and multiplexes it between the FFT core (writer) and the decoder (reader). It keeps good-frame, bad-frame, overrun and timeout statistics.

---
 rtl/ofdm_pkg.sv | 32 +++
 rtl/ofdm_sat_cnt.sv | 30 +++
 rtl/ofdm_rx_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_ofdm_rx_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared definitions for the OFDM receive sequencer.
//   - FSM state encoding (3-bit) and BSRAM port owner encoding
//   - payload, BSRAM address and data widths
//   - watchdog expiry helper
package ofdm_pkg;

  localparam int PAYLOAD_W = 96;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FFT_RUN = 3'd1,
    ST_GUARD   = 3'd2,
    ST_DEC_RUN = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_FFT  = 2'd1,
    OWN_DEC  = 2'd2
  } owner_t;

  // True in the cycle whose count completes the allowed budget: the
  // watchdog starts at 0 on entry, so the limit-th cycle sees limit-1.
  function automatic logic wd_expired(input logic [15:0] wd, input logic [15:0] limit);
    return (wd == (limit - 16'd1));
  endfunction

endpackage

// File: rtl/ofdm_sat_cnt.sv
// ofdm_sat_cnt: saturating up-counter used for receive statistics.
//   clk   in   clock
//   rst_n in   asynchronous active-low reset
//   inc   in   count one event this cycle
//   cnt   out  current count, sticks at all-ones
module ofdm_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_r;

  // Event counter; holds once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (inc && !(&cnt_r)) begin
      cnt_r <= cnt_r + WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/ofdm_rx_ctrl.sv
// ofdm_rx_ctrl: per-symbol receive sequencer.
//   Runs FFT core, then the subcarrier decoder, then hands the 96-bit payload
//   downstream over a valid/ready register. Owns the shared FFT-result BSRAM
//   port and steers it to the FFT core (writer) or decoder (reader).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   en                              start enable, sampled in IDLE only
//   symbol_ready / symbol_ack       captured symbol level / consume pulse
//   fft_start / fft_finish          FFT core handshake
//   fft_ce/oce/wre/ad/din           FFT core BSRAM request
//   dec_start / dec_finish          decoder handshake, dec_success/dec_res valid with finish
//   dec_ce/oce/ad                   decoder BSRAM request
//   ram_ce/oce/wre/ad/din           shared BSRAM port
//   frame_valid/frame_data/ready    payload output register
//   good/bad/ovr/tmo_cnt            saturating statistics
//   busy                            state is not IDLE
module ofdm_rx_ctrl
  import ofdm_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd8191
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 symbol_ready,
  output logic                 symbol_ack,
  output logic                 fft_start,
  input  logic                 fft_finish,
  input  logic                 fft_ce,
  input  logic                 fft_oce,
  input  logic                 fft_wre,
  input  logic [ADDR_W-1:0]    fft_ad,
  input  logic [DATA_W-1:0]    fft_din,
  output logic                 dec_start,
  input  logic                 dec_finish,
  input  logic                 dec_success,
  input  logic [PAYLOAD_W-1:0] dec_res,
  input  logic                 dec_ce,
  input  logic                 dec_oce,
  input  logic [ADDR_W-1:0]    dec_ad,
  output logic                 ram_ce,
  output logic                 ram_oce,
  output logic                 ram_wre,
  output logic [ADDR_W-1:0]    ram_ad,
  output logic [DATA_W-1:0]    ram_din,
  output logic                 frame_valid,
  output logic [PAYLOAD_W-1:0] frame_data,
  input  logic                 frame_ready,
  output logic [CNT_W-1:0]     good_cnt,
  output logic [CNT_W-1:0]     bad_cnt,
  output logic [CNT_W-1:0]     ovr_cnt,
  output logic [CNT_W-1:0]     tmo_cnt,
  output logic                 busy
);

  state_t               state_r;
  owner_t               owner_r;
  logic [15:0]          wd_r;
  logic                 sym_q_r;
  logic                 fft_start_r;
  logic                 symbol_ack_r;
  logic                 dec_start_r;
  logic                 frame_valid_r;
  logic [PAYLOAD_W-1:0] frame_data_r;
  logic                 busy_r;

  logic                 wd_hit_s;
  logic                 good_inc_s;
  logic                 bad_inc_s;
  logic                 ovr_inc_s;
  logic                 tmo_inc_s;

  assign wd_hit_s = wd_expired(wd_r, TIMEOUT);

  // Statistic events; a finish in the expiry cycle counts as completion, not timeout.
  always_comb begin
    good_inc_s = 1'b0;
    bad_inc_s  = 1'b0;
    tmo_inc_s  = 1'b0;
    ovr_inc_s  = busy_r && symbol_ready && !sym_q_r;
    if (state_r == ST_DEC_RUN) begin
      good_inc_s = dec_finish && dec_success;
      bad_inc_s  = dec_finish && !dec_success;
      tmo_inc_s  = !dec_finish && wd_hit_s;
    end else if (state_r == ST_FFT_RUN) begin
      tmo_inc_s  = !fft_finish && wd_hit_s;
    end else begin
      tmo_inc_s  = 1'b0;
    end
  end

  // Sequencer FSM with registered pulses, owner, payload register and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      owner_r       <= OWN_NONE;
      wd_r          <= 16'd0;
      sym_q_r       <= 1'b0;
      fft_start_r   <= 1'b0;
      symbol_ack_r  <= 1'b0;
      dec_start_r   <= 1'b0;
      frame_valid_r <= 1'b0;
      frame_data_r  <= {PAYLOAD_W{1'b0}};
      busy_r        <= 1'b0;
    end else begin
      fft_start_r  <= 1'b0;
      symbol_ack_r <= 1'b0;
      dec_start_r  <= 1'b0;
      sym_q_r      <= symbol_ready;
      case (state_r)
        ST_IDLE: begin
          if (en && symbol_ready) begin
            state_r      <= ST_FFT_RUN;
            owner_r      <= OWN_FFT;
            fft_start_r  <= 1'b1;
            symbol_ack_r <= 1'b1;
            wd_r         <= 16'd0;
            busy_r       <= 1'b1;
          end
        end
        ST_FFT_RUN: begin
          if (fft_finish) begin
            state_r <= ST_GUARD;
            owner_r <= OWN_NONE;
            wd_r    <= 16'd0;
          end else if (wd_hit_s) begin
            state_r <= ST_IDLE;
            owner_r <= OWN_NONE;
            wd_r    <= 16'd0;
            busy_r  <= 1'b0;
          end else begin
            wd_r    <= wd_r + 16'd1;
          end
        end
        // One idle cycle between writer and reader so no BSRAM access overlaps.
        ST_GUARD: begin
          state_r     <= ST_DEC_RUN;
          owner_r     <= OWN_DEC;
          dec_start_r <= 1'b1;
          wd_r        <= 16'd0;
        end
        ST_DEC_RUN: begin
          if (dec_finish) begin
            owner_r <= OWN_NONE;
            wd_r    <= 16'd0;
            if (dec_success) begin
              state_r       <= ST_OUTPUT;
              frame_data_r  <= dec_res;
              frame_valid_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else if (wd_hit_s) begin
            state_r <= ST_IDLE;
            owner_r <= OWN_NONE;
            wd_r    <= 16'd0;
            busy_r  <= 1'b0;
          end else begin
            wd_r    <= wd_r + 16'd1;
          end
        end
        ST_OUTPUT: begin
          if (frame_ready) begin
            state_r       <= ST_IDLE;
            frame_valid_r <= 1'b0;
            busy_r        <= 1'b0;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          owner_r       <= OWN_NONE;
          wd_r          <= 16'd0;
          frame_valid_r <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  // BSRAM port steering from the registered owner; decoder never writes.
  always_comb begin
    ram_ce  = 1'b0;
    ram_oce = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = {ADDR_W{1'b0}};
    ram_din = {DATA_W{1'b0}};
    case (owner_r)
      OWN_FFT: begin
        ram_ce  = fft_ce;
        ram_oce = fft_oce;
        ram_wre = fft_wre;
        ram_ad  = fft_ad;
        ram_din = fft_din;
      end
      OWN_DEC: begin
        ram_ce  = dec_ce;
        ram_oce = dec_oce;
        ram_ad  = dec_ad;
      end
      default: begin
        ram_ce  = 1'b0;
        ram_oce = 1'b0;
      end
    endcase
  end

  ofdm_sat_cnt #(.WIDTH(CNT_W)) u_good_cnt (.clk(clk), .rst_n(rst_n), .inc(good_inc_s), .cnt(good_cnt));
  ofdm_sat_cnt #(.WIDTH(CNT_W)) u_bad_cnt  (.clk(clk), .rst_n(rst_n), .inc(bad_inc_s),  .cnt(bad_cnt));
  ofdm_sat_cnt #(.WIDTH(CNT_W)) u_ovr_cnt  (.clk(clk), .rst_n(rst_n), .inc(ovr_inc_s),  .cnt(ovr_cnt));
  ofdm_sat_cnt #(.WIDTH(CNT_W)) u_tmo_cnt  (.clk(clk), .rst_n(rst_n), .inc(tmo_inc_s),  .cnt(tmo_cnt));

  assign symbol_ack  = symbol_ack_r;
  assign fft_start   = fft_start_r;
  assign dec_start   = dec_start_r;
  assign frame_valid = frame_valid_r;
  assign frame_data  = frame_data_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_ofdm_rx_ctrl.sv
// tb_ofdm_rx_ctrl: directed, table-driven bench for ofdm_rx_ctrl.
// Watchdog limit is 64 so a 40-cycle FFT fits and the finish-vs-expiry
// boundary can be hit with a 64-cycle latency.
module tb_ofdm_rx_ctrl;

  localparam logic [15:0] TMO = 16'd64;

  logic        clk, rst_n, en, symbol_ready, symbol_ack, fft_start, fft_finish;
  logic        fft_ce, fft_oce, fft_wre, dec_start, dec_finish, dec_success;
  logic [10:0] fft_ad, dec_ad, ram_ad;
  logic [31:0] fft_din, ram_din;
  logic [95:0] dec_res, frame_data;
  logic        dec_ce, dec_oce, ram_ce, ram_oce, ram_wre, frame_valid, frame_ready, busy;
  logic [15:0] good_cnt, bad_cnt, ovr_cnt, tmo_cnt;
  logic        sc_inc;
  logic [3:0]  sc_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  ofdm_rx_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .symbol_ready(symbol_ready), .symbol_ack(symbol_ack),
    .fft_start(fft_start), .fft_finish(fft_finish), .fft_ce(fft_ce), .fft_oce(fft_oce),
    .fft_wre(fft_wre), .fft_ad(fft_ad), .fft_din(fft_din), .dec_start(dec_start),
    .dec_finish(dec_finish), .dec_success(dec_success), .dec_res(dec_res), .dec_ce(dec_ce),
    .dec_oce(dec_oce), .dec_ad(dec_ad), .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
    .ram_ad(ram_ad), .ram_din(ram_din), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_ready(frame_ready), .good_cnt(good_cnt), .bad_cnt(bad_cnt), .ovr_cnt(ovr_cnt),
    .tmo_cnt(tmo_cnt), .busy(busy)
  );

  // Narrow instance of the statistics counter so saturation is reachable quickly.
  ofdm_sat_cnt #(.WIDTH(4)) u_sc (.clk(clk), .rst_n(rst_n), .inc(sc_inc), .cnt(sc_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          fft_lat;
    int          dec_lat;
    logic        success;
    logic [95:0] payload;
    logic        exp_valid;
    logic [15:0] exp_good;
    logic [15:0] exp_bad;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    en = 1'b0; symbol_ready = 1'b0; fft_finish = 1'b0; fft_ce = 1'b0; fft_oce = 1'b0;
    fft_wre = 1'b0; fft_ad = 11'd0; fft_din = 32'd0; dec_finish = 1'b0; dec_success = 1'b0;
    dec_res = 96'd0; dec_ce = 1'b0; dec_oce = 1'b0; dec_ad = 11'd0; frame_ready = 1'b0;
    sc_inc = 1'b0;
  endtask

  logic [95:0] bp_payload;
  logic        flag;

  initial begin
    vecs[0] = '{40, 10, 1'b1, 96'h5555_5555_5555_5555_5555_5555, 1'b1, 16'd1, 16'd0};
    vecs[1] = '{5,  3,  1'b0, 96'hFFFF_0000_FFFF_0000_FFFF_0000, 1'b0, 16'd1, 16'd1};
    vecs[2] = '{1,  1,  1'b1, 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 1'b1, 16'd2, 16'd1};
    vecs[3] = '{64, 64, 1'b1, 96'h0123_4567_89AB_CDEF_0123_4567, 1'b1, 16'd3, 16'd1};
    vecs[4] = '{12, 7,  1'b0, 96'h0000_0000_0000_0000_0000_0001, 1'b0, 16'd3, 16'd2};
    bp_payload = 96'hC0FF_EE00_1234_5678_9ABC_DEF0;

    // Reset state
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_fft_start", fft_start, 1'b0);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_frame_data", frame_data, 96'd0);
    chk("rst_good", good_cnt, 16'd0);
    chk("rst_ram_ce", ram_ce, 1'b0);
    rst_n = 1'b1;
    en = 1'b1;
    tick();

    // Stray finish pulses in IDLE are ignored
    fft_finish = 1'b1; dec_finish = 1'b1; dec_success = 1'b1;
    tick();
    fft_finish = 1'b0; dec_finish = 1'b0; dec_success = 1'b0;
    chk("stray_busy", busy, 1'b0);
    chk("stray_dec_start", dec_start, 1'b0);
    chk("stray_good", good_cnt, 16'd0);
    tick();

    // Table-driven symbols
    for (int i = 0; i < 5; i++) begin
      symbol_ready = 1'b1;
      tick();
      chk($sformatf("v%0d_fft_start", i), fft_start, 1'b1);
      chk($sformatf("v%0d_symbol_ack", i), symbol_ack, 1'b1);
      symbol_ready = 1'b0;
      for (int k = 1; k < vecs[i].fft_lat; k++) begin
        tick();
        if (k == 1) chk($sformatf("v%0d_fft_start_pulse", i), fft_start, 1'b0);
      end
      fft_finish = 1'b1;
      tick();
      fft_finish = 1'b0;
      chk($sformatf("v%0d_guard_busy", i), busy, 1'b1);
      chk($sformatf("v%0d_guard_no_dec_start", i), dec_start, 1'b0);
      tick();
      chk($sformatf("v%0d_dec_start", i), dec_start, 1'b1);
      for (int k = 1; k < vecs[i].dec_lat; k++) begin
        tick();
        if (k == 1) chk($sformatf("v%0d_dec_start_pulse", i), dec_start, 1'b0);
      end
      dec_finish = 1'b1; dec_success = vecs[i].success; dec_res = vecs[i].payload;
      tick();
      dec_finish = 1'b0; dec_success = 1'b0; dec_res = 96'd0;
      chk($sformatf("v%0d_frame_valid", i), frame_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_good", i), good_cnt, vecs[i].exp_good);
      chk($sformatf("v%0d_bad", i), bad_cnt, vecs[i].exp_bad);
      chk($sformatf("v%0d_tmo", i), tmo_cnt, 16'd0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_frame_data", i), frame_data, vecs[i].payload);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk($sformatf("v%0d_valid_drop", i), frame_valid, 1'b0);
      end
      chk($sformatf("v%0d_idle", i), busy, 1'b0);
    end

    // Backpressure with overrun
    symbol_ready = 1'b1;
    tick();
    symbol_ready = 1'b0;
    fft_finish = 1'b1;
    tick();
    fft_finish = 1'b0;
    tick();
    dec_finish = 1'b1; dec_success = 1'b1; dec_res = bp_payload;
    tick();
    dec_finish = 1'b0; dec_success = 1'b0; dec_res = 96'd0;
    chk("bp_valid", frame_valid, 1'b1);
    chk("bp_good", good_cnt, 16'd4);
    symbol_ready = 1'b1;
    tick();
    chk("bp_ovr", ovr_cnt, 16'd1);
    flag = 1'b0;
    repeat (100) begin
      tick();
      if (fft_start !== 1'b0 || frame_valid !== 1'b1 || frame_data !== bp_payload) flag = 1'b1;
    end
    chk("bp_hold", flag, 1'b0);
    chk("bp_ovr_once", ovr_cnt, 16'd1);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("bp_release_valid", frame_valid, 1'b0);
    chk("bp_release_no_start", fft_start, 1'b0);
    tick();
    chk("bp_next_start", fft_start, 1'b1);
    symbol_ready = 1'b0;

    // Timeout: fft_finish withheld for the whole budget
    fft_ce = 1'b1;
    flag = 1'b0;
    repeat (63) begin
      tick();
      if (dec_start !== 1'b0) flag = 1'b1;
    end
    chk("tmo_last_cycle_busy", busy, 1'b1);
    chk("tmo_last_cycle_cnt", tmo_cnt, 16'd0);
    chk("tmo_last_cycle_ram_ce", ram_ce, 1'b1);
    tick();
    chk("tmo_cnt", tmo_cnt, 16'd1);
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_ram_ce", ram_ce, 1'b0);
    repeat (4) begin
      tick();
      if (dec_start !== 1'b0) flag = 1'b1;
    end
    chk("tmo_no_dec_start", flag, 1'b0);

    // en=0 blocks a start in IDLE
    en = 1'b0;
    symbol_ready = 1'b1;
    repeat (3) tick();
    chk("en_block_busy", busy, 1'b0);
    chk("en_block_ovr", ovr_cnt, 16'd1);

    // Port mux across owners
    fft_ad = 11'h155; dec_ad = 11'h2AA; fft_oce = 1'b1; fft_wre = 1'b1;
    fft_din = 32'hDEAD_BEEF; dec_ce = 1'b1; dec_oce = 1'b1;
    #1;
    chk("mux_idle_ad", ram_ad, 11'h000);
    en = 1'b1;
    tick();
    chk("mux_start", fft_start, 1'b1);
    chk("mux_fft_ad", ram_ad, 11'h155);
    chk("mux_fft_wre", ram_wre, 1'b1);
    chk("mux_fft_din", ram_din, 32'hDEAD_BEEF);
    symbol_ready = 1'b0;
    en = 1'b0;
    fft_finish = 1'b1;
    tick();
    fft_finish = 1'b0;
    chk("mux_guard_ad", ram_ad, 11'h000);
    chk("mux_guard_ce", ram_ce, 1'b0);
    chk("mux_guard_busy_en0", busy, 1'b1);
    tick();
    chk("mux_dec_start", dec_start, 1'b1);
    chk("mux_dec_ad", ram_ad, 11'h2AA);
    chk("mux_dec_wre", ram_wre, 1'b0);
    chk("mux_dec_din", ram_din, 32'd0);
    chk("mux_dec_ce", ram_ce, 1'b1);
    tick();

    // Asynchronous reset in the middle of DEC_RUN
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ram_ce", ram_ce, 1'b0);
    chk("arst_ram_ad", ram_ad, 11'h000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_good", good_cnt, 16'd0);
    chk("arst_ovr", ovr_cnt, 16'd0);
    chk("arst_tmo", tmo_cnt, 16'd0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();
    chk("arst_after_busy", busy, 1'b0);
    chk("arst_after_dec_start", dec_start, 1'b0);

    // Counter saturation on the narrow instance
    sc_inc = 1'b1;
    repeat (14) tick();
    chk("sat_count", sc_cnt, 4'hE);
    repeat (6) tick();
    chk("sat_top", sc_cnt, 4'hF);
    sc_inc = 1'b0;
    tick();
    chk("sat_hold", sc_cnt, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
